// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for seq_alu.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_ASHL  = 3'd1,
        OP_XNOR  = 3'd2,
        OP_DIV   = 3'd3,
        OP_PASSB = 3'd4,
        OP_PASSA = 3'd5,
        OP_NEG   = 3'd6,
        OP_ROUND = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/seq_alu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses one cycle
// after the last bit. Only instantiated when SEQ_ALU_DIV_EN is defined.
module seq_alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_busy, r_done;

    logic [WIDTH-1:0] w_src_rem, w_src_quo, w_src_dvs;
    logic [WIDTH:0]   w_shift, w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt;

    // The first iteration runs in the start cycle straight from the operands,
    // so WIDTH iterations finish in time for the owner to register the result.
    always_comb begin
        w_src_rem = start ? '0       : r_rem;
        w_src_quo = start ? dividend : r_quo;
        w_src_dvs = start ? divisor  : r_dvs;
        w_shift   = {w_src_rem, w_src_quo[WIDTH-1]};
        w_diff    = w_shift - {1'b0, w_src_dvs};
        w_ge      = ~w_diff[WIDTH];
        w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_nxt = {w_src_quo[WIDTH-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= w_rem_nxt;
            r_quo  <= w_quo_nxt;
            r_dvs  <= divisor;
            r_cnt  <= CW'(1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/seq_alu.sv
// Registered eight-op ALU with valid/ready on both sides.
// SEQ_ALU_DIV_EN selects the iterative divider; otherwise DIV is op2>>1 in one cycle.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             co,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic             r_co, r_zero;

    alu_op_e          w_op;
    logic             w_accept, w_is_div, w_div_done;
    logic [WIDTH-1:0] w_res, w_pow;
    logic             w_co_new, w_co_wr, w_found;
    logic [WIDTH:0]   w_sum, w_shl;

    assign w_op     = alu_op_e'(sel);
    assign w_accept = in_valid & in_ready;

`ifdef SEQ_ALU_DIV_EN
    logic             r_dz;
    logic [WIDTH-1:0] w_quo, w_rem;

    assign w_is_div = (w_op == OP_DIV);

    seq_alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_accept & w_is_div),
        .dividend  (op1),
        .divisor   (op2),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );
`else
    assign w_is_div   = 1'b0;
    assign w_div_done = 1'b0;
`endif

    always_comb begin
        w_sum   = {1'b0, op1} + {1'b0, op2};
        w_shl   = {1'b0, op2} << op1[SHW-1:0];
        w_pow   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (!w_found && ((WIDTH'(1) << k) >= op2)) begin
                w_pow   = WIDTH'(1) << k;
                w_found = 1'b1;
            end
        end
        w_res    = '0;
        w_co_new = 1'b0;
        w_co_wr  = 1'b0;
        case (w_op)
            OP_ADD:   begin w_res = w_sum[WIDTH-1:0]; w_co_new = w_sum[WIDTH]; w_co_wr = 1'b1; end
            // Bit WIDTH of the widened shift is the last bit shifted out (0 for no shift).
            OP_ASHL:  begin w_res = w_shl[WIDTH-1:0]; w_co_new = w_shl[WIDTH]; w_co_wr = 1'b1; end
            OP_XNOR:  w_res = ~(op1 ^ op2);
            OP_DIV:   begin
`ifndef SEQ_ALU_DIV_EN
                w_res    = op2 >> 1;
                w_co_new = op2[0];
                w_co_wr  = 1'b1;
`endif
            end
            OP_PASSB: w_res = op2;
            OP_PASSA: w_res = op1;
            OP_NEG:   w_res = ~op2 + WIDTH'(1);
            OP_ROUND: w_res = w_pow;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_div ? ST_BUSY : ST_DONE;
                end else if (r_state == ST_DONE && out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_div_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
        out_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_co   <= 1'b0;
            r_zero <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            r_dz   <= 1'b0;
`endif
        end else if (w_accept && !w_is_div) begin
            r_out  <= w_res;
            r_zero <= (w_res == '0);
            if (w_co_wr) begin
                r_co <= w_co_new;
            end
`ifdef SEQ_ALU_DIV_EN
        end else if (w_accept) begin
            r_dz <= (op2 == '0);
        end else if (w_div_done) begin
            // Divide by zero reports all ones with co set regardless of the dividend.
            r_out  <= r_dz ? '1 : w_quo;
            r_co   <= r_dz | (w_rem != '0);
            r_zero <= !r_dz && (w_quo == '0);
`endif
        end
    end

    assign out  = r_out;
    assign co   = r_co;
    assign zero = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8); expectations follow SEQ_ALU_DIV_EN if defined.
module tb_seq_alu;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] op1, op2, out;
    logic [2:0] sel;
    logic       co, zero;

    typedef struct {
        logic [7:0] o;
        logic       c;
        logic       z;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_issued = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .co        (co),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one operation, hold it until accepted, queue its expected result.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit push, input logic [7:0] eo, input logic ec, input logic ez,
                         output int waits);
        sel = op; op1 = a; op2 = b; in_valid = 1'b1; waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk($sformatf("accept timeout op %0d", n_issued), 32'(in_ready), 32'd1);
        end else if (push) begin
            q.push_back('{o: eo, c: ec, z: ez, id: n_issued});
        end
        n_issued++;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every consumed result is compared against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected result", 32'(out), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("op %0d out", e.id), 32'(out), 32'(e.o));
                    chk($sformatf("op %0d co", e.id), 32'(co), 32'(e.c));
                    chk($sformatf("op %0d zero", e.id), 32'(zero), 32'(e.z));
                end
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; sel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out", 32'(out), 32'd0);
        chk("reset co/zero", 32'({co, zero}), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: add with carry, then xnor leaves co untouched
        issue(OP_ADD, 8'hF0, 8'h20, 1, 8'h10, 1'b1, 1'b0, w);
        chk("add latency out_valid", 32'(out_valid), 32'd1);
        issue(OP_XNOR, 8'hFF, 8'hFF, 1, 8'hFF, 1'b1, 1'b0, w);

        // 2/3: divide
`ifdef SEQ_ALU_DIV_EN
        issue(OP_DIV, 8'd200, 8'd7, 1, 8'd28, 1'b1, 1'b0, w);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("div busy cycle %0d valid/ready", i), 32'({out_valid, in_ready}), 32'd0);
            @(posedge clk); #1;
        end
        chk("div out_valid at cycle 9", 32'(out_valid), 32'd1);
        issue(OP_DIV, 8'h55, 8'h00, 1, 8'hFF, 1'b1, 1'b0, w);
        issue(OP_DIV, 8'd12, 8'd4, 1, 8'd3, 1'b0, 1'b0, w);
`else
        issue(OP_DIV, 8'd200, 8'd7, 1, 8'h03, 1'b1, 1'b0, w);
        chk("div out_valid at cycle 1", 32'(out_valid), 32'd1);
        issue(OP_DIV, 8'h55, 8'h00, 1, 8'h00, 1'b0, 1'b1, w);
        issue(OP_DIV, 8'd12, 8'd4, 1, 8'h02, 1'b0, 1'b0, w);
`endif

        // 4: shifts, rounding boundaries, pass/negate
        issue(OP_ASHL,  8'h01, 8'h81, 1, 8'h02, 1'b1, 1'b0, w);
        issue(OP_ROUND, 8'h00, 8'h21, 1, 8'h40, 1'b1, 1'b0, w);
        issue(OP_ROUND, 8'h00, 8'h00, 1, 8'h01, 1'b1, 1'b0, w);
        issue(OP_ROUND, 8'h00, 8'h81, 1, 8'h00, 1'b1, 1'b1, w);
        issue(OP_ROUND, 8'h00, 8'h80, 1, 8'h80, 1'b1, 1'b0, w);
        issue(OP_ASHL,  8'h00, 8'hFF, 1, 8'hFF, 1'b0, 1'b0, w);
        issue(OP_PASSA, 8'h5A, 8'h00, 1, 8'h5A, 1'b0, 1'b0, w);
        issue(OP_ASHL,  8'h03, 8'h3F, 1, 8'hF8, 1'b1, 1'b0, w);
        issue(OP_PASSB, 8'h00, 8'hA5, 1, 8'hA5, 1'b1, 1'b0, w);
        issue(OP_NEG,   8'h00, 8'h01, 1, 8'hFF, 1'b1, 1'b0, w);
        issue(OP_NEG,   8'h00, 8'h00, 1, 8'h00, 1'b1, 1'b1, w);
        issue(OP_XNOR,  8'h0F, 8'h33, 1, 8'hC3, 1'b1, 1'b0, w);
        issue(OP_ADD,   8'h80, 8'h80, 1, 8'h00, 1'b1, 1'b1, w);
        issue(OP_ASHL,  8'hF9, 8'h40, 1, 8'h80, 1'b0, 1'b0, w);

        // 5: backpressure holds the result, then same-cycle handoff
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(OP_ADD, 8'h7F, 8'h01, 1, 8'h80, 1'b0, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall %0d out", i), 32'(out), 32'h80);
            chk($sformatf("stall %0d co/zero/valid/in_ready", i),
                32'({co, zero, out_valid, in_ready}), 32'b0010);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(OP_PASSA, 8'h00, 8'h77, 1, 8'h00, 1'b0, 1'b1, w);
        chk("handoff accept waits", 32'(w), 32'd0);

        // 6: reset while an operation is in flight
        issue(OP_ADD, 8'hFF, 8'h02, 1, 8'h01, 1'b1, 1'b0, w);
`ifdef SEQ_ALU_DIV_EN
        issue(OP_DIV, 8'd200, 8'd7, 0, 8'h00, 1'b0, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
`else
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(OP_ADD, 8'h10, 8'h10, 0, 8'h00, 1'b0, 1'b0, w);
`endif
        rst_n = 1'b0;
        #1;
        chk("mid-op reset out", 32'(out), 32'd0);
        chk("mid-op reset co", 32'(co), 32'd0);
        chk("mid-op reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        issue(OP_ADD, 8'h33, 8'h44, 1, 8'h77, 1'b0, 1'b0, w);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("scoreboard drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
